// File: rtl/systolic_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// systolic_seq_ctrl_pkg: shared types for the systolic array sequencer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package systolic_seq_ctrl_pkg;

  typedef struct packed {
    logic [1:0] in_fmt;
    logic [1:0] acc_fmt;
  } full_type_t;

  typedef enum logic [2:0] {
    SEQ_IDLE  = 3'd0,
    SEQ_CLOAD = 3'd1,
    SEQ_FEED  = 3'd2,
    SEQ_DRAIN = 3'd3,
    SEQ_DONE  = 3'd4
  } seq_state_t;

  localparam int SEQ_ROWS = 4;
  localparam int SEQ_COLS = 4;

endpackage

`default_nettype wire

// File: rtl/systolic_seq_ctrl_skew_gen.sv
// ---------------------------------------------------------------------------
// systolic_seq_ctrl_skew_gen: per-lane skewed enable / K-index decoder. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module systolic_seq_ctrl_skew_gen #(
  parameter int GW   = 7,
  parameter int KW   = 7,
  parameter int IW   = 6,
  parameter int LANE = 0
) (
  input  logic [GW-1:0] g_i,
  input  logic [KW-1:0] k_i,
  output logic          en_o,
  output logic [IW-1:0] idx_o
);

  // One spare bit so lane + K never overflows the compare.
  localparam int EW = ((GW > KW) ? GW : KW) + 1;

  logic [EW-1:0] g_ext;
  logic [EW-1:0] k_ext;
  logic [EW-1:0] lane_ext;

  assign g_ext    = EW'(g_i);
  assign k_ext    = EW'(k_i);
  assign lane_ext = EW'(LANE);

  assign en_o  = (g_ext >= lane_ext) && (g_ext < (lane_ext + k_ext));
  assign idx_o = en_o ? IW'(g_ext - lane_ext) : '0;

endmodule

`default_nettype wire

// File: rtl/systolic_seq_ctrl.sv
// ---------------------------------------------------------------------------
// systolic_seq_ctrl: C-preload, skewed feed and drain sequencer for the array. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module systolic_seq_ctrl
  import systolic_seq_ctrl_pkg::*;
#(
  parameter int ROWS   = SEQ_ROWS,
  parameter int COLS   = SEQ_COLS,
  parameter int K_MAX  = 64,
  parameter int KW     = $clog2(K_MAX + 1),
  parameter int IW     = $clog2(K_MAX),
  parameter int PE_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [KW-1:0]      k_len,
  input  logic               c_preload,
  input  full_type_t         compute_type_in,
  output logic               busy,
  output logic               done,
  output full_type_t         compute_type_out,
  output logic               cin_en,
  output logic [ROWS-1:0]    row_en,
  output logic [COLS-1:0]    col_en,
  output logic [ROWS*IW-1:0] a_k_idx,
  output logic [COLS*IW-1:0] b_k_idx
);

  localparam int GW     = $clog2(K_MAX + ROWS + COLS + PE_LAT);
  localparam int MAX_RC = (ROWS > COLS) ? ROWS : COLS;

  seq_state_t state_q, state_d;
  logic [GW-1:0] g_q, g_d;
  logic [KW-1:0] k_q, k_d;
  full_type_t    type_q, type_d;

  logic feed_last;
  logic drain_last;
  logic feeding;

  // Last enable leaves the sequencer at g = K+max(R,C)-2; the far corner PE
  // result is final PE_LAT cycles after its last enable at g = K+R+C-3.
  assign feed_last  = (int'(g_q) == (int'(k_q) + MAX_RC - 2));
  assign drain_last = (int'(g_q) >= (int'(k_q) + ROWS + COLS - 4 + PE_LAT));
  assign feeding    = (state_q == SEQ_FEED);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SEQ_IDLE;
      g_q     <= '0;
      k_q     <= '0;
      type_q  <= '0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      k_q     <= k_d;
      type_q  <= type_d;
    end
  end

  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    k_d     = k_q;
    type_d  = type_q;
    unique case (state_q)
      SEQ_IDLE: begin
        g_d = '0;
        if (start) begin
          k_d    = k_len;
          type_d = compute_type_in;
          if (k_len == '0)    state_d = SEQ_DONE;
          else if (c_preload) state_d = SEQ_CLOAD;
          else                state_d = SEQ_FEED;
        end
      end
      SEQ_CLOAD: begin
        // g doubles as the C-chain cycle counter: one fill plus COLS shifts.
        if (g_q == GW'(COLS)) begin
          g_d     = '0;
          state_d = SEQ_FEED;
        end else begin
          g_d = g_q + 1'b1;
        end
      end
      SEQ_FEED: begin
        g_d = g_q + 1'b1;
        if (feed_last) state_d = SEQ_DRAIN;
      end
      SEQ_DRAIN: begin
        g_d = g_q + 1'b1;
        if (drain_last) state_d = SEQ_DONE;
      end
      SEQ_DONE: begin
        g_d     = '0;
        state_d = SEQ_IDLE;
      end
      default: begin
        g_d     = '0;
        state_d = SEQ_IDLE;
      end
    endcase
  end

  assign busy             = (state_q != SEQ_IDLE);
  assign done             = (state_q == SEQ_DONE);
  assign cin_en           = (state_q == SEQ_CLOAD);
  assign compute_type_out = type_q;

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    logic          en;
    logic [IW-1:0] idx;

    systolic_seq_ctrl_skew_gen #(
      .GW  (GW),
      .KW  (KW),
      .IW  (IW),
      .LANE(i)
    ) u_skew (
      .g_i  (g_q),
      .k_i  (k_q),
      .en_o (en),
      .idx_o(idx)
    );

    assign row_en[i]            = feeding & en;
    assign a_k_idx[i*IW +: IW]  = feeding ? idx : '0;
  end

  for (genvar j = 0; j < COLS; j++) begin : g_col
    logic          en;
    logic [IW-1:0] idx;

    systolic_seq_ctrl_skew_gen #(
      .GW  (GW),
      .KW  (KW),
      .IW  (IW),
      .LANE(j)
    ) u_skew (
      .g_i  (g_q),
      .k_i  (k_q),
      .en_o (en),
      .idx_o(idx)
    );

    assign col_en[j]            = feeding & en;
    assign b_k_idx[j*IW +: IW]  = feeding ? idx : '0;
  end

  a_k_len_range : assert property (@(posedge clk) disable iff (rst)
    (start && (state_q == SEQ_IDLE)) |-> (int'(k_len) <= K_MAX));

endmodule

`default_nettype wire
